// File: rtl/prefix_sequencer_pkg.sv
// Shared front-end decode types: segment/rep encodings, the prefix bundle handed to the
// opcode decoder, the prefix byte values and the sequencer state encoding.
package prefix_sequencer_pkg;

    typedef enum logic [2:0] {
        SEG_ES = 3'd0,
        SEG_CS = 3'd1,
        SEG_SS = 3'd2,
        SEG_DS = 3'd3,
        SEG_FS = 3'd4,
        SEG_GS = 3'd5
    } seg_t;

    typedef enum logic [1:0] {
        REP_NONE = 2'b00,
        REP_NE   = 2'b10,
        REP_E    = 2'b11
    } rep_t;

    typedef struct packed {
        logic       opsize;
        logic       addrsize;
        logic       lock;
        rep_t       rep;
        logic       seg_valid;
        seg_t       seg;
        logic [3:0] count;
    } prefix_bundle_t;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_PRESENT = 2'd1,
        ST_FAULT   = 2'd2
    } seq_state_t;

    localparam logic [7:0] PFX_ES       = 8'h26;
    localparam logic [7:0] PFX_CS       = 8'h2E;
    localparam logic [7:0] PFX_SS       = 8'h36;
    localparam logic [7:0] PFX_DS       = 8'h3E;
    localparam logic [7:0] PFX_FS       = 8'h64;
    localparam logic [7:0] PFX_GS       = 8'h65;
    localparam logic [7:0] PFX_OPSIZE   = 8'h66;
    localparam logic [7:0] PFX_ADDRSIZE = 8'h67;
    localparam logic [7:0] PFX_LOCK     = 8'hF0;
    localparam logic [7:0] PFX_REPNE    = 8'hF2;
    localparam logic [7:0] PFX_REPE     = 8'hF3;

    localparam int MAX_PREFIX_DEFAULT = 14;

endpackage

// File: rtl/prefix_sequencer_decode_prefix.sv
// Combinational classifier for one instruction byte. The rep flavour (F2 vs F3) is left
// to the caller; here both only count as prefixes.
module decode_prefix
    import prefix_sequencer_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic       is_prefix,
    output logic       is_seg,
    output seg_t       seg,
    output logic       is_opsize,
    output logic       is_addrsize,
    output logic       is_lock
);

    always_comb begin
        is_seg      = 1'b1;
        seg         = SEG_ES;
        is_opsize   = 1'b0;
        is_addrsize = 1'b0;
        is_lock     = 1'b0;
        is_prefix   = 1'b1;
        case (in_byte)
            PFX_ES:       seg = SEG_ES;
            PFX_CS:       seg = SEG_CS;
            PFX_SS:       seg = SEG_SS;
            PFX_DS:       seg = SEG_DS;
            PFX_FS:       seg = SEG_FS;
            PFX_GS:       seg = SEG_GS;
            PFX_OPSIZE:   begin is_seg = 1'b0; is_opsize = 1'b1; end
            PFX_ADDRSIZE: begin is_seg = 1'b0; is_addrsize = 1'b1; end
            PFX_LOCK:     begin is_seg = 1'b0; is_lock = 1'b1; end
            PFX_REPNE,
            PFX_REPE:     is_seg = 1'b0;
            default:      begin is_seg = 1'b0; is_prefix = 1'b0; end
        endcase
    end

endmodule

// File: rtl/prefix_sequencer.sv
// Accumulates x86 prefix bytes until the opcode byte arrives, then presents
// {prefix bundle, opcode} downstream with a valid/ready handshake.
module prefix_sequencer
    import prefix_sequencer_pkg::*;
#(
    parameter int MAX_PREFIX = MAX_PREFIX_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       flush,
    input  logic       default_size,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_opcode,
    output logic       out_operand_size,
    output logic       out_address_size,
    output logic       out_lock,
    output logic [1:0] out_rep,
    output logic       out_seg_valid,
    output logic [2:0] out_seg,
    output logic [3:0] out_prefix_count,
    output logic       prefix_fault
);

    if (MAX_PREFIX > 15 || MAX_PREFIX < 0) begin : g_bad_max_prefix
        $error("prefix_sequencer: MAX_PREFIX must fit the 4-bit prefix count");
    end

    seq_state_t     state, state_next;
    prefix_bundle_t bundle, bundle_next;
    logic [7:0]     opcode, opcode_next;
    logic           fault, fault_next;

    logic is_prefix, is_seg, is_opsize, is_addrsize, is_lock;
    seg_t seg;

    decode_prefix u_decode_prefix (
        .in_byte     (in_byte),
        .is_prefix   (is_prefix),
        .is_seg      (is_seg),
        .seg         (seg),
        .is_opsize   (is_opsize),
        .is_addrsize (is_addrsize),
        .is_lock     (is_lock)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_COLLECT;
            bundle <= '0;
            opcode <= 8'h00;
            fault  <= 1'b0;
        end else begin
            state  <= state_next;
            bundle <= bundle_next;
            opcode <= opcode_next;
            fault  <= fault_next;
        end
    end

    // Flush wins over any coincident byte accept or output handshake.
    always_comb begin
        state_next  = state;
        bundle_next = bundle;
        opcode_next = opcode;
        fault_next  = fault;
        if (flush) begin
            state_next  = ST_COLLECT;
            bundle_next = '0;
            opcode_next = 8'h00;
            fault_next  = 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (in_valid) begin
                        if (!is_prefix) begin
                            opcode_next = in_byte;
                            state_next  = ST_PRESENT;
                        end else if (bundle.count >= 4'(MAX_PREFIX)) begin
                            fault_next = 1'b1;
                            state_next = ST_FAULT;
                        end else begin
                            bundle_next.count = bundle.count + 4'd1;
                            if (is_opsize)   bundle_next.opsize   = 1'b1;
                            if (is_addrsize) bundle_next.addrsize = 1'b1;
                            if (is_lock)     bundle_next.lock     = 1'b1;
                            if (is_seg) begin
                                bundle_next.seg_valid = 1'b1;
                                bundle_next.seg       = seg;
                            end
                            if (in_byte == PFX_REPNE) bundle_next.rep = REP_NE;
                            if (in_byte == PFX_REPE)  bundle_next.rep = REP_E;
                        end
                    end
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        bundle_next = '0;
                        state_next  = ST_COLLECT;
                    end
                end
                ST_FAULT: begin
                    state_next = ST_FAULT;
                end
                default: begin
                    state_next = ST_COLLECT;
                end
            endcase
        end
    end

    assign in_ready         = (state == ST_COLLECT);
    assign out_valid        = (state == ST_PRESENT);
    assign out_opcode       = opcode;
    assign out_operand_size = default_size ^ bundle.opsize;
    assign out_address_size = default_size ^ bundle.addrsize;
    assign out_lock         = bundle.lock;
    assign out_rep          = bundle.rep;
    assign out_seg_valid    = bundle.seg_valid;
    assign out_seg          = bundle.seg;
    assign out_prefix_count = bundle.count;
    assign prefix_fault     = fault;

endmodule
